instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter DEPTH, 4, output buffer entries; power of two, at least 2.
REQ-002 Parameter ADDR_W, 8, width of the instruction word address counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  encode request present.
REQ-006 req_ready  output  1  encoder accepts the request this cycle.
REQ-007 req_op  input  4  operation select: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 lw, 6 sw, 7 beq, 8 addi, 9 j; 10-15 illegal.
REQ-008 req_rs, req_rt, req_rd  input  5 each  register fields.
REQ-009 req_imm  input  16  immediate or branch offset.
REQ-010 req_target  input  26  jump target field.
REQ-011 out_valid  output  1  encoded word available.
REQ-012 out_ready  input  1  downstream instruction-memory loader takes the word.
REQ-013 out_instr  output  32  encoded MIPS instruction word, head of buffer.
REQ-014 out_addr  output  ADDR_W  word address paired with out_instr.
REQ-015 level  output  clog2(DEPTH)+1  buffer occupancy.
REQ-016 err_illegal  output  1  sticky illegal-op flag.
REQ-017 clear_err  input  1  synchronous clear of err_illegal.

Function
REQ-018 Request handshake SHALL complete when req_valid and req_ready are both high on a rising edge; output handshake SHALL complete when out_valid and out_ready are both high.
REQ-019 req_ready SHALL equal (level < DEPTH) and SHALL NOT depend combinationally on out_ready.
REQ-020 R-type ops 0-4 SHALL encode opcode 000000, rs, rt, rd, shamt 00000, funct 0x20/0x22/0x24/0x25/0x2A respectively.
REQ-021 I-type ops SHALL encode {opcode, rs, rt, imm}, with opcodes lw 0x23, sw 0x2B, beq 0x04, addi 0x08.
REQ-022 j SHALL encode {000010, req_target}; unused request fields SHALL be ignored.
REQ-023 Encoding SHALL be registered into the buffer: a word accepted at edge N SHALL be visible on out_instr with out_valid high after edge N, when the buffer was empty, giving 1-cycle latency.
REQ-024 The buffer SHALL be FIFO ordered, with pointers wrapping modulo DEPTH.
REQ-025 Simultaneous push and pop SHALL leave level unchanged, including at level DEPTH (the pop frees space only on the next cycle, per REQ-019) and at level 0 (no push-through).
REQ-026 out_valid SHALL equal (level != 0); out_instr and out_addr SHALL hold stable while out_valid is high and out_ready is low.
REQ-027 out_addr SHALL start at 0 and increment by 1 on each output handshake, wrapping from 2^ADDR_W-1 to 0.
REQ-028 An illegal req_op SHALL be accepted (handshake completes) but SHALL NOT be enqueued; err_illegal SHALL be set on the following edge.
REQ-029 err_illegal SHALL remain set until clear_err is sampled high; if clear_err and a new illegal acceptance occur on the same edge, set SHALL win.
REQ-030 level SHALL be the count of valid entries, 0..DEPTH, and SHALL never exceed DEPTH.

Reset
REQ-031 When reset_n is low: level 0, out_valid 0, out_addr 0, err_illegal 0, read and write pointers 0, and req_ready 1 one edge after reset_n is released.
REQ-032 Assertion mid-operation SHALL discard all buffered words immediately, without waiting for clk.
REQ-033 Buffer data storage need not be reset; out_instr is don't-care while out_valid is 0.

Verification
REQ-034 Send add rs=1, rt=2, rd=3 with out_ready=1 -> next cycle out_instr=0x00221820, out_addr=0.
REQ-035 Send lw rs=29, rt=8, imm=0x0004, then beq rs=1, rt=2, imm=0xFFFF, then j target=0x10 -> in order 0x8FA80004, 0x1022FFFF, 0x08000010 at out_addr 0, 1, 2.
REQ-036 Hold out_ready=0 and push 5 requests -> req_ready drops after 4 accepted, level=4; set out_ready=1 -> the 4 words drain in order and req_ready returns high.
REQ-037 Send req_op=12 -> nothing enqueued, level unchanged, err_illegal=1; pulse clear_err -> 0; clear_err with simultaneous illegal op -> stays 1.
REQ-038 Complete 256 output handshakes -> out_addr wraps 255 to 0; assert reset_n=0 with 3 words buffered -> out_valid=0, level=0 without a clock edge.

Source files
------------

// File: rtl/instr_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_encoder : MIPS instruction encoder with addressed output FIFO
// Revision 1.0
// ---------------------------------------------------------------------------
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [3:0]                 req_op,
  input  logic [4:0]                 req_rs,
  input  logic [4:0]                 req_rt,
  input  logic [4:0]                 req_rd,
  input  logic [15:0]                req_imm,
  input  logic [25:0]                req_target,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       err_illegal,
  input  logic                       clear_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] C_FULL = LVL_W'(DEPTH);

  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  logic [31:0] enc_word;
  logic        enc_legal;
  logic        accept, push, pop;

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (req_op)
      4'd0:    enc_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h20};
      4'd1:    enc_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h22};
      4'd2:    enc_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h24};
      4'd3:    enc_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h25};
      4'd4:    enc_word = {6'h00, req_rs, req_rt, req_rd, 5'd0, 6'h2A};
      4'd5:    enc_word = {6'h23, req_rs, req_rt, req_imm};
      4'd6:    enc_word = {6'h2B, req_rs, req_rt, req_imm};
      4'd7:    enc_word = {6'h04, req_rs, req_rt, req_imm};
      4'd8:    enc_word = {6'h08, req_rs, req_rt, req_imm};
      4'd9:    enc_word = {6'h02, req_target};
      default: enc_legal = 1'b0;
    endcase
  end

  // Ready comes from occupancy only, so a pop at full frees space next cycle.
  assign req_ready = (level_q != C_FULL);
  assign out_valid = (level_q != '0);
  assign accept    = req_valid && req_ready;
  assign push      = accept && enc_legal;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    addr_d   = addr_q;
    err_d    = err_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      addr_d   = addr_q + 1'b1;
    end
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
    // Set has priority over clear on the same edge.
    if (accept && !enc_legal) err_d = 1'b1;
    else if (clear_err)       err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= enc_word;
  end

  assign out_instr   = mem_q[rd_ptr_q];
  assign out_addr    = addr_q;
  assign level       = level_q;
  assign err_illegal = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_instr_encoder : scoreboard bench for instr_encoder
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [4:0]  req_rs = '0, req_rt = '0, req_rd = '0;
  logic [15:0] req_imm = '0;
  logic [25:0] req_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [7:0]  out_addr;
  logic [2:0]  level;
  logic        err_illegal;
  logic        clear_err = 1'b0;

  instr_encoder #(.DEPTH(4), .ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_imm(req_imm), .req_target(req_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .level(level),
    .err_illegal(err_illegal), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [7:0]  addr;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  exp_addr = '0;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: inputs change just after posedge, so negedge sees a stable handshake.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got 0x%08h expected no word", out_instr);
      end else begin
        e = sb.pop_front();
        chk("sb_instr", out_instr, e.instr);
        chk("sb_addr", 32'(out_addr), 32'(e.addr));
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                      input logic legal, input logic [31:0] exp_word);
    int n = 0;
    exp_t e;
    req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt; req_rd = rd;
    req_imm = imm; req_target = tgt;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      total++; bad++;
      $display("FAIL send_timeout: req_ready stuck low, expected high");
    end else if (legal) begin
      e.instr = exp_word;
      e.addr  = exp_addr;
      exp_addr = exp_addr + 8'd1;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    sb.delete();
    exp_addr = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_addr", 32'(out_addr), 0);
    chk("rst_err", 32'(err_illegal), 0);
    chk("rst_ready", 32'(req_ready), 1);

    // add with 1-cycle latency
    out_ready = 1'b1;
    chk("pre_valid", 32'(out_valid), 0);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h00221820);
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_instr", out_instr, 32'h00221820);
    wait_drain();

    // lw / beq / j ordered stream from address 0, back-to-back push+pop
    do_reset();
    send(4'd5, 5'd29, 5'd8, 5'd0, 16'h0004, 26'h0, 1'b1, 32'h8FA80004);
    chk("lvl_stream1", 32'(level), 1);
    send(4'd7, 5'd1, 5'd2, 5'd0, 16'hFFFF, 26'h0, 1'b1, 32'h1022FFFF);
    chk("lvl_stream2", 32'(level), 1);
    send(4'd9, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10, 1'b1, 32'h08000010);
    wait_drain();

    // remaining encodings; unused fields carry junk that must be ignored
    send(4'd1, 5'd4, 5'd5, 5'd6, 16'hABCD, 26'h1, 1'b1, 32'h00853022);
    send(4'd2, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b1, 32'h00E84824);
    send(4'd3, 5'd31, 5'd31, 5'd31, 16'h0, 26'h0, 1'b1, 32'h03FFF825);
    send(4'd4, 5'd10, 5'd11, 5'd12, 16'h0, 26'h0, 1'b1, 32'h014B602A);
    send(4'd6, 5'd29, 5'd31, 5'd0, 16'h0010, 26'h0, 1'b1, 32'hAFBF0010);
    send(4'd8, 5'd0, 5'd1, 5'd5, 16'h1234, 26'h0, 1'b1, 32'h20011234);
    send(4'd9, 5'd5, 5'd6, 5'd7, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h0BFFFFFF);
    wait_drain();

    // backpressure: fill to DEPTH, check stall and stability, then drain
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(4'd8, 5'd2, 5'd3, 5'd0, 16'(i + 1), 26'h0, 1'b1, 32'h20430000 | 32'(i + 1));
    chk("full_level", 32'(level), 4);
    chk("full_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("stall_instr", out_instr, 32'h20430001);
    chk("stall_addr", 32'(out_addr), 0);
    chk("stall_level", 32'(level), 4);
    out_ready = 1'b1;
    send(4'd8, 5'd2, 5'd3, 5'd0, 16'h0005, 26'h0, 1'b1, 32'h20430005);
    wait_drain();
    chk("drain_ready", 32'(req_ready), 1);
    chk("drain_level", 32'(level), 0);

    // illegal op handling and sticky error
    send(4'd12, 5'd1, 5'd1, 5'd1, 16'h0, 26'h0, 1'b0, 32'h0);
    chk("ill_err", 32'(err_illegal), 1);
    chk("ill_level", 32'(level), 0);
    chk("ill_valid", 32'(out_valid), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("ill_sticky", 32'(err_illegal), 1);
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
    chk("clr_err", 32'(err_illegal), 0);
    clear_err = 1'b1;
    send(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0, 32'h0);
    clear_err = 1'b0;
    chk("set_wins", 32'(err_illegal), 1);
    send(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1, 32'h00221820);
    chk("legal_keeps_err", 32'(err_illegal), 1);
    wait_drain();
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;

    // address wrap: 257 words, the last lands at address 0 again
    do_reset();
    for (int i = 0; i < 257; i++)
      send(4'd8, 5'd0, 5'd1, 5'd0, 16'(i), 26'h0, 1'b1, 32'h20010000 | 32'(i));
    wait_drain();
    chk("wrap_addr", 32'(out_addr), 1);

    // asynchronous reset with 3 words buffered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      send(4'd0, 5'(i), 5'd0, 5'd0, 16'h0, 26'h0, 1'b1, {6'h00, 5'(i), 15'h0, 6'h20});
    chk("pre_arst_level", 32'(level), 3);
    #2;
    reset_n = 1'b0;
    sb.delete();
    exp_addr = '0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_level", 32'(level), 0);
    chk("arst_addr", 32'(out_addr), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_arst_ready", 32'(req_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
